// File: rtl/onchip_ram_pipe.sv
// onchip_ram_pipe: pipelined on-chip RAM slave with post-reset zero-fill and range checking.
// Define ONCHIP_RAM_PARITY_EN to add per-byte even parity storage and read checking.
module onchip_ram_pipe #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 13,
  parameter int DEPTH          = 5120,
  parameter int OUTREG         = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    reset_req,
  input  logic                    clken,
  input  logic                    chipselect,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_WIDTH-1:0]   writedata,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,
  output logic                    waitrequest,
  output logic                    clear_busy,
  output logic                    range_err,
  output logic                    parity_err
);
  localparam int BE = DATA_WIDTH / 8;
  typedef enum logic {CLEAR, READY} state_t;
  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] d1_q, d2_q, hold_q, rd_stage;
  logic v1_q, v2_q, range_err_q;
  logic en, acc, rd_acc, wr_ok, clr_we, in_range;
`ifdef ONCHIP_RAM_PARITY_EN
  logic [BE-1:0] par_q [DEPTH];
  logic [BE-1:0] p1_q, p2_q, p_calc;
  logic perr_q, perr_now;
`endif
  assign en          = clken & ~reset_req;
  assign clear_busy  = state_q == CLEAR;
  assign waitrequest = clear_busy | ~en;
  assign acc         = chipselect & (read | write) & ~waitrequest;
  assign in_range    = 32'(address) < DEPTH;
  assign rd_acc      = acc & read & ~write;
  assign wr_ok       = acc & write & in_range & ~reset;
  assign clr_we      = clear_busy & en & ~reset;
  assign range_err   = range_err_q;
  // Valid is only presented on enabled cycles so a stalled result is not seen twice.
  assign rd_stage      = (OUTREG != 0) ? d2_q : d1_q;
  assign readdatavalid = ((OUTREG != 0) ? v2_q : v1_q) & en;
  assign readdata      = readdatavalid ? rd_stage : hold_q;
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (clear_busy && en) begin
      state_d   = (32'(clr_cnt_q) == DEPTH - 1) ? READY : CLEAR;
      clr_cnt_d = (32'(clr_cnt_q) == DEPTH - 1) ? '0 : clr_cnt_q + ADDR_WIDTH'(1);
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RST_STATE;
      clr_cnt_q   <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      d1_q        <= '0;
      d2_q        <= '0;
      hold_q      <= '0;
      range_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      range_err_q <= range_err_q | (acc & ~in_range);
      if (readdatavalid) hold_q <= rd_stage;
      if (en) begin
        v1_q <= rd_acc;
        v2_q <= v1_q;
      end
      if (rd_acc) d1_q <= in_range ? mem_q[address] : '0;
      if (en && v1_q) d2_q <= d1_q;
    end
  end
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_cnt_q] <= '0;
`ifdef ONCHIP_RAM_PARITY_EN
      par_q[clr_cnt_q] <= '0;
`endif
    end else if (wr_ok) begin
      for (int i = 0; i < BE; i++) begin
        if (byteenable[i]) begin
          mem_q[address][8*i +: 8] <= writedata[8*i +: 8];
`ifdef ONCHIP_RAM_PARITY_EN
          par_q[address][i] <= ^writedata[8*i +: 8];
`endif
        end
      end
    end
  end
`ifdef ONCHIP_RAM_PARITY_EN
  always_comb begin
    p_calc = '0;
    for (int i = 0; i < BE; i++) p_calc[i] = ^rd_stage[8*i +: 8];
  end
  assign perr_now   = readdatavalid & (p_calc != ((OUTREG != 0) ? p2_q : p1_q));
  assign parity_err = perr_q | perr_now;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p1_q   <= '0;
      p2_q   <= '0;
      perr_q <= 1'b0;
    end else begin
      perr_q <= parity_err;
      if (rd_acc) p1_q <= in_range ? par_q[address] : '0;
      if (en && v1_q) p2_q <= p1_q;
    end
  end
`else
  assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_onchip_ram_pipe.sv
// tb_onchip_ram_pipe: directed checks of a latency-1 and a latency-2 instance driven in lockstep.
module tb_onchip_ram_pipe;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEP = 16;
  logic clk = 1'b0;
  logic reset, reset_req, clken, chipselect, read, write;
  logic [AW-1:0] address;
  logic [3:0] byteenable;
  logic [DW-1:0] writedata, rd0, rd1;
  logic v0, v1, w0, w1, cb0, cb1, re0, re1, pe0, pe1;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  onchip_ram_pipe #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEP), .OUTREG(0), .CLEAR_ON_RESET(1)) dut0 (
    .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken), .chipselect(chipselect),
    .address(address), .byteenable(byteenable), .read(read), .write(write), .writedata(writedata),
    .readdata(rd0), .readdatavalid(v0), .waitrequest(w0), .clear_busy(cb0), .range_err(re0), .parity_err(pe0));
  onchip_ram_pipe #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEP), .OUTREG(1), .CLEAR_ON_RESET(1)) dut1 (
    .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken), .chipselect(chipselect),
    .address(address), .byteenable(byteenable), .read(read), .write(write), .writedata(writedata),
    .readdata(rd1), .readdatavalid(v1), .waitrequest(w1), .clear_busy(cb1), .range_err(re1), .parity_err(pe1));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [3:0] be, input logic [DW-1:0] d);
    chipselect = 1'b1; write = 1'b1; read = 1'b0; address = a; byteenable = be; writedata = d;
    step();
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    logic bad;
    reset = 1'b1; reset_req = 1'b0; clken = 1'b1; chipselect = 1'b0; read = 1'b0; write = 1'b0;
    address = '0; byteenable = '0; writedata = '0;
    #2;
    checks++; if (rd0 !== '0 || rd1 !== '0) begin errors++; $display("FAIL rst_readdata: got %h/%h want 0", rd0, rd1); end
    checks++; if (v0 !== 1'b0 || v1 !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b/%b want 0", v0, v1); end
    checks++; if (re0 !== 1'b0 || re1 !== 1'b0 || pe0 !== 1'b0 || pe1 !== 1'b0) begin errors++; $display("FAIL rst_flags: got %b%b%b%b want 0000", re0, re1, pe0, pe1); end
    checks++; if (cb1 !== 1'b1 || w1 !== 1'b1) begin errors++; $display("FAIL rst_busy: got cb=%b wr=%b want 1 1", cb1, w1); end
    step(); step();
    reset = 1'b0;
    n = 0; bad = 1'b0;
    while (cb1 === 1'b1 && n < 100) begin
      if (w1 !== 1'b1 || cb0 !== 1'b1) bad = 1'b1;
      n++;
      step();
    end
    checks++; if (n != 16) begin errors++; $display("FAIL clear_len: got %0d want 16", n); end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL clear_waitreq: got gap=%b want 0", bad); end
    checks++; if (w1 !== 1'b0 || cb0 !== 1'b0) begin errors++; $display("FAIL ready_idle: got wr=%b cb0=%b want 0 0", w1, cb0); end
  endtask

  task automatic test_clear_zero();
    for (int i = 0; i < DEP; i += 5) begin
      chipselect = 1'b1; read = 1'b1; address = AW'(i);
      step();
      chipselect = 1'b0; read = 1'b0;
      #1;
      checks++; if (v0 !== 1'b1 || rd0 !== '0) begin errors++; $display("FAIL clear_zero[%0d]: got v=%b d=%h want 1 0", i, v0, rd0); end
    end
    step();
  endtask

  task automatic test_write_bytes();
    wr(5, 4'hF, 32'hAABBCCDD);
    wr(5, 4'h5, 32'h11223344);
    chipselect = 1'b1; read = 1'b1; address = 5;
    step();
    chipselect = 1'b0; read = 1'b0;
    #1;
    checks++; if (v0 !== 1'b1 || rd0 !== 32'hAA22CC44) begin errors++; $display("FAIL lat1_read: got v=%b d=%h want 1 aa22cc44", v0, rd0); end
    checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL lat2_early: got v=%b want 0", v1); end
    step(); #1;
    checks++; if (v1 !== 1'b1 || rd1 !== 32'hAA22CC44) begin errors++; $display("FAIL lat2_read: got v=%b d=%h want 1 aa22cc44", v1, rd1); end
    checks++; if (v0 !== 1'b0 || rd0 !== 32'hAA22CC44) begin errors++; $display("FAIL lat1_hold: got v=%b d=%h want 0 aa22cc44", v0, rd0); end
    step();
  endtask

  task automatic test_rw_collision();
    chipselect = 1'b1; read = 1'b1; write = 1'b1; address = 6; byteenable = 4'hF; writedata = 32'h12345678;
    step();
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
    #1;
    checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL rw_no_valid0: got %b want 0", v0); end
    step(); #1;
    checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL rw_no_valid1: got %b want 0", v1); end
    chipselect = 1'b1; read = 1'b1; address = 6;
    step();
    chipselect = 1'b0; read = 1'b0;
    #1;
    checks++; if (v0 !== 1'b1 || rd0 !== 32'h12345678) begin errors++; $display("FAIL rw_written: got v=%b d=%h want 1 12345678", v0, rd0); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [9:0] em, m0, m1;
    int p, n0, n1;
    for (int i = 0; i < 4; i++) wr(AW'(i), 4'hF, 32'h1000_0000 + i);
    for (int pass = 0; pass < 2; pass++) begin
      em = (pass == 1) ? 10'b1111110011 : 10'b1111111111;
      m1 = (pass == 1) ? 10'b0011110000 : 10'b0000111100;
      m0 = (pass == 1) ? 10'b0001110010 : 10'b0000011110;
      p = 0; n0 = 0; n1 = 0;
      for (int k = 0; k < 10; k++) begin
        clken = em[k]; chipselect = p < 4; read = p < 4; address = AW'(p);
        #1;
        checks++; if (v1 !== m1[k]) begin errors++; $display("FAIL b2b_valid2 p%0d c%0d: got %b want %b", pass, k, v1, m1[k]); end
        if (m1[k]) begin
          checks++; if (rd1 !== 32'h1000_0000 + n1) begin errors++; $display("FAIL b2b_data2 p%0d c%0d: got %h want %h", pass, k, rd1, 32'h1000_0000 + n1); end
          n1++;
        end
        checks++; if (v0 !== m0[k]) begin errors++; $display("FAIL b2b_valid1 p%0d c%0d: got %b want %b", pass, k, v0, m0[k]); end
        if (m0[k]) begin
          checks++; if (rd0 !== 32'h1000_0000 + n0) begin errors++; $display("FAIL b2b_data1 p%0d c%0d: got %h want %h", pass, k, rd0, 32'h1000_0000 + n0); end
          n0++;
        end
        if (!em[k]) begin
          checks++; if (w1 !== 1'b1) begin errors++; $display("FAIL b2b_stall_wr c%0d: got %b want 1", k, w1); end
        end
        step();
        if (em[k] && p < 4) p++;
      end
      chipselect = 1'b0; read = 1'b0; clken = 1'b1;
      step();
    end
  endtask

  task automatic test_reset_req();
    chipselect = 1'b1; read = 1'b1; address = 2;
    step();
    chipselect = 1'b0; read = 1'b0; reset_req = 1'b1;
    #1;
    checks++; if (w0 !== 1'b1 || v0 !== 1'b0) begin errors++; $display("FAIL rreq_freeze: got wr=%b v=%b want 1 0", w0, v0); end
    step(); step();
    reset_req = 1'b0;
    #1;
    checks++; if (v0 !== 1'b1 || rd0 !== 32'h1000_0002) begin errors++; $display("FAIL rreq_resume1: got v=%b d=%h want 1 10000002", v0, rd0); end
    step(); #1;
    checks++; if (v0 !== 1'b0 || v1 !== 1'b1 || rd1 !== 32'h1000_0002) begin errors++; $display("FAIL rreq_resume2: got v0=%b v1=%b d=%h want 0 1 10000002", v0, v1, rd1); end
    step();
  endtask

  task automatic test_range();
    checks++; if (re0 !== 1'b0 || re1 !== 1'b0) begin errors++; $display("FAIL range_pre: got %b/%b want 0", re0, re1); end
    chipselect = 1'b1; read = 1'b1; address = AW'(DEP + 1);
    step();
    chipselect = 1'b0; read = 1'b0;
    #1;
    checks++; if (v0 !== 1'b1 || rd0 !== '0 || re0 !== 1'b1) begin errors++; $display("FAIL range_read1: got v=%b d=%h e=%b want 1 0 1", v0, rd0, re0); end
    step(); #1;
    checks++; if (v1 !== 1'b1 || rd1 !== '0 || re1 !== 1'b1) begin errors++; $display("FAIL range_read2: got v=%b d=%h e=%b want 1 0 1", v1, rd1, re1); end
    wr(AW'(DEP + 1), 4'hF, 32'hFFFFFFFF);
    chipselect = 1'b1; read = 1'b1; address = 1;
    step();
    chipselect = 1'b0; read = 1'b0;
    #1;
    checks++; if (rd0 !== 32'h1000_0001) begin errors++; $display("FAIL range_nowrite1: got %h want 10000001", rd0); end
    step();
    chipselect = 1'b1; read = 1'b1; address = 5;
    step();
    chipselect = 1'b0; read = 1'b0;
    #1;
    checks++; if (rd0 !== 32'hAA22CC44) begin errors++; $display("FAIL range_nowrite5: got %h want aa22cc44", rd0); end
    step(); step();
    checks++; if (re0 !== 1'b1 || re1 !== 1'b1) begin errors++; $display("FAIL range_sticky: got %b/%b want 1", re0, re1); end
  endtask

  task automatic test_clear_restart();
    int n;
    logic stray;
    wr(12, 4'hF, 32'hDEADBEEF);
    chipselect = 1'b1; read = 1'b1; address = 5;
    step();
    chipselect = 1'b0; read = 1'b0; reset = 1'b1;
    #1;
    checks++; if (v0 !== 1'b0 || v1 !== 1'b0 || rd0 !== '0) begin errors++; $display("FAIL rst_drop_read: got v=%b%b d=%h want 00 0", v0, v1, rd0); end
    checks++; if (re0 !== 1'b0 || cb0 !== 1'b1) begin errors++; $display("FAIL rst_state: got e=%b cb=%b want 0 1", re0, cb0); end
    step(); step();
    reset = 1'b0;
    repeat (7) step();
    reset = 1'b1;
    #1;
    checks++; if (cb1 !== 1'b1) begin errors++; $display("FAIL midclear_busy: got %b want 1", cb1); end
    step();
    reset = 1'b0;
    n = 0; stray = 1'b0;
    while (cb1 === 1'b1 && n < 100) begin
      if (v0 !== 1'b0 || v1 !== 1'b0) stray = 1'b1;
      n++;
      step();
    end
    checks++; if (n != 16) begin errors++; $display("FAIL restart_len: got %0d want 16", n); end
    checks++; if (stray !== 1'b0) begin errors++; $display("FAIL restart_stray_valid: got %b want 0", stray); end
    chipselect = 1'b1; read = 1'b1; address = 12;
    step();
    chipselect = 1'b0; read = 1'b0;
    #1;
    checks++; if (v0 !== 1'b1 || rd0 !== '0) begin errors++; $display("FAIL restart_zero12: got v=%b d=%h want 1 0", v0, rd0); end
    step();
  endtask

  task automatic test_parity();
    logic exp_pe;
    logic [DW-1:0] exp_d;
`ifdef ONCHIP_RAM_PARITY_EN
    exp_pe = 1'b1; exp_d = 32'h000000FE;
`else
    exp_pe = 1'b0; exp_d = 32'h000000FF;
`endif
    wr(3, 4'hF, 32'h000000FF);
`ifdef ONCHIP_RAM_PARITY_EN
    dut0.mem_q[3][0] = ~dut0.mem_q[3][0];
    dut1.mem_q[3][0] = ~dut1.mem_q[3][0];
`endif
    chipselect = 1'b1; read = 1'b1; address = 3;
    step();
    chipselect = 1'b0; read = 1'b0;
    #1;
    checks++; if (v0 !== 1'b1 || rd0 !== exp_d || pe0 !== exp_pe) begin errors++; $display("FAIL parity1: got v=%b d=%h pe=%b want 1 %h %b", v0, rd0, pe0, exp_d, exp_pe); end
    checks++; if (pe1 !== 1'b0) begin errors++; $display("FAIL parity2_early: got %b want 0", pe1); end
    step(); #1;
    checks++; if (v1 !== 1'b1 || rd1 !== exp_d || pe1 !== exp_pe) begin errors++; $display("FAIL parity2: got v=%b d=%h pe=%b want 1 %h %b", v1, rd1, pe1, exp_d, exp_pe); end
    step(); step();
    checks++; if (pe0 !== exp_pe || pe1 !== exp_pe) begin errors++; $display("FAIL parity_sticky: got %b/%b want %b", pe0, pe1, exp_pe); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_clear_zero();
    test_write_bytes();
    test_rw_collision();
    test_back_to_back();
    test_reset_req();
    test_range();
    test_clear_restart();
    test_parity();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/onchip_ram_pipe.md
ONCHIP_RAM_PIPE -- requirements
Module: onchip_ram_pipe

Interface
- REQ-001 SHALL have parameter DATA_WIDTH, default 32: data bus width in bits; multiple of 8, 8..128.
- REQ-002 SHALL have parameter ADDR_WIDTH, default 13: word address width.
- REQ-003 SHALL have parameter DEPTH, default 5120: word count; must satisfy DEPTH <= 2**ADDR_WIDTH.
- REQ-004 SHALL have parameter OUTREG, default 0: 0 gives read latency 1; 1 gives read latency 2 (registered output).
- REQ-005 SHALL have parameter CLEAR_ON_RESET, default 1: 1 zero-fills the memory after reset.
- REQ-006 SHALL have port clk, input, 1: sole clock; all logic rising-edge.
- REQ-007 SHALL have port reset, input, 1: asynchronous, active-high reset.
- REQ-008 SHALL have port reset_req, input, 1: high freezes the block exactly as clken=0 does.
- REQ-009 SHALL have port clken, input, 1: global clock enable.
- REQ-010 SHALL have port chipselect, input, 1: slave select.
- REQ-011 SHALL have port address, input, ADDR_WIDTH: word address.
- REQ-012 SHALL have port byteenable, input, DATA_WIDTH/8: write byte lanes.
- REQ-013 SHALL have ports read and write, input, 1 each: transfer requests.
- REQ-014 SHALL have port writedata, input, DATA_WIDTH: write data.
- REQ-015 SHALL have port readdata, output, DATA_WIDTH: read data.
- REQ-016 SHALL have port readdatavalid, output, 1: one-cycle pulse per completed read.
- REQ-017 SHALL have port waitrequest, output, 1: stalls the master.
- REQ-018 SHALL have port clear_busy, output, 1: zero-fill in progress.
- REQ-019 SHALL have port range_err, output, 1: sticky out-of-range access flag.
- REQ-020 SHALL have port parity_err, output, 1: sticky parity error flag.

Function
- REQ-021 SHALL run an FSM with states CLEAR and READY; after reset it enters CLEAR if CLEAR_ON_RESET=1, else READY.
- REQ-022 In CLEAR, while enabled, it SHALL write zero to one word per cycle at addresses 0..DEPTH-1 in order, then enter READY on the cycle after the write to DEPTH-1.
- REQ-023 waitrequest SHALL equal (state==CLEAR) | ~clken | reset_req; clear_busy SHALL equal (state==CLEAR).
- REQ-024 A transfer is accepted when chipselect & (read|write) & ~waitrequest.
- REQ-025 An accepted write SHALL update only the bytes whose byteenable bit is set.
- REQ-026 An accepted read SHALL drive readdata and pulse readdatavalid exactly 1+OUTREG enabled cycles after acceptance; reads SHALL be fully pipelined, one per cycle.
- REQ-027 A read of an address written on the previous cycle SHALL return the new data.
- REQ-028 When read and write are asserted together, the write SHALL be performed and the read ignored, with no readdatavalid.
- REQ-029 An access with address >= DEPTH SHALL leave memory unchanged, SHALL set range_err, and, for a read, SHALL return zero with readdatavalid.
- REQ-030 While disabled (~clken | reset_req), the clear counter, FSM and read pipeline SHALL hold; in-flight reads SHALL complete after re-enable with latency counted in enabled cycles only.
- REQ-031 readdata SHALL hold its last value between readdatavalid pulses.

Reset
- REQ-032 Asynchronous reset SHALL force readdata=0, readdatavalid=0, range_err=0, parity_err=0, the pipeline empty, the clear counter to 0, and the FSM to its REQ-021 state.
- REQ-033 A reset mid-CLEAR SHALL restart the zero-fill from address 0; a reset mid-read SHALL drop the read with no readdatavalid.
- REQ-034 With CLEAR_ON_RESET=0, reset SHALL NOT alter memory contents.

Configuration
- REQ-035 With ONCHIP_RAM_PARITY_EN defined, the block SHALL store one even-parity bit per byte (written on write and on clear) and check it on every read; a mismatch SHALL set parity_err in the same cycle as readdatavalid.
- REQ-036 With ONCHIP_RAM_PARITY_EN undefined, no parity storage SHALL exist and parity_err SHALL be tied to 0.

Verification
- REQ-037 With CLEAR_ON_RESET=1 and DEPTH=16, release reset -> clear_busy and waitrequest high for exactly 16 enabled cycles; every subsequent read returns 0.
- REQ-038 Write 0xAABBCCDD at address 5 with byteenable=4'b1111, then write 0x11223344 with byteenable=4'b0101 -> read at address 5 returns 0xAA22CC44, with readdatavalid 1 cycle after acceptance (OUTREG=0) or 2 cycles (OUTREG=1).
- REQ-039 Issue back-to-back reads of addresses 0..3 with OUTREG=1 -> four consecutive readdatavalid pulses returning the data in order; drop clken for 2 cycles mid-burst -> the pulses slip by exactly 2 cycles.
- REQ-040 Read address DEPTH+1 -> readdata=0 with readdatavalid, range_err=1 until reset; a write to that address leaves all words unchanged.
- REQ-041 Assert reset at clear count 7 -> the fill restarts from address 0 and clear_busy lasts a full DEPTH cycles.
- REQ-042 With ONCHIP_RAM_PARITY_EN defined, write 0x000000FF at address 3, flip bit 0 of the stored word by hierarchical deposit, then read it -> parity_err=1 on the readdatavalid cycle; without the macro, parity_err stays 0.
